dmem_bridge: RTL and testbench

Data-memory access unit between the MEM stage of the 5-stage MIPS pipeline and a variable-latency word-wide data bus. It takes the MEM-stage request (ren/wen/addr/dout) and runs one request/acknowledge transaction on the bus. While the transaction is pending it raises a stall so the controller freezes the pipeline. It then returns read data on mem_din.

---
 rtl/dmem_bridge_pkg.sv | 13 +
 rtl/dmem_bridge.sv | 137 +++++++++++++
 tb/tb_dmem_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and the
// read-data value returned when a bus transaction is aborted.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_bridge.sv
// MEM-stage to request/acknowledge data-bus bridge; stalls the pipeline while a
// transaction is pending. Define DMEM_TIMEOUT_EN for the REQ timeout abort.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_timeout
);

  dmem_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  req;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Byte-offset bits are deliberately dropped: accesses are always word-aligned.
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_addr[1:0], (TIMEOUT_CYCLES != 0)};

  assign req = mem_ren | mem_wen;

  always_comb begin
    state_d     = state_q;
    mem_din_d   = mem_din_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_stall   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      DMEM_IDLE: begin
        mem_stall = req;
        if (req) begin
          bus_addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_we_d    = mem_wen;
          bus_wdata_d = mem_dout;
          bus_req_d   = 1'b1;
          state_d     = DMEM_REQ;
`ifdef DMEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      DMEM_REQ: begin
        mem_stall = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_din_d = bus_rdata;
          state_d = DMEM_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        // The limit is reached on the edge that would bring the count to TIMEOUT_CYCLES.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_din_d = DATA_WIDTH'(DMEM_ABORT_DATA);
          timeout_d = 1'b1;
          state_d   = DMEM_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DMEM_IDLE;
      mem_din_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_din_q   <= mem_din_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus_timeout = timeout_q;
`else
  assign bus_timeout = 1'b0;
`endif

  assign mem_din   = mem_din_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: vector table with a scoreboard queue,
// plus reset and (with DMEM_TIMEOUT_EN) timeout sequences.
module tb_dmem_bridge;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk, rst;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_timeout;

  dmem_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_stall  (mem_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_timeout(bus_timeout)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic        b2b;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] rdata;
    int unsigned waits;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_din;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rises = 0;
  int unsigned exp_rises = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus_req) rises++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 500000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts in an IDLE cycle right after a negedge; returns at the DONE negedge.
  task automatic access(input vec_t v);
    exp_t e;
    mem_ren  = v.ren;
    mem_wen  = v.wen;
    mem_addr = v.addr;
    mem_dout = v.dout;
    e.we = v.exp_we; e.addr = v.exp_addr; e.wdata = v.dout; e.din = v.exp_din;
    sb.push_back(e);
    exp_rises++;
    #1 check("idle_stall", {31'b0, mem_stall}, 32'd1);
    @(negedge clk);
    for (int unsigned c = 0; c <= v.waits; c++) begin
      check("req_held", {31'b0, bus_req}, 32'd1);
      check("req_stall", {31'b0, mem_stall}, 32'd1);
      check("bus_we", {31'b0, bus_we}, {31'b0, sb[0].we});
      check("bus_addr", bus_addr, sb[0].addr);
      if (sb[0].we) check("bus_wdata", bus_wdata, sb[0].wdata);
      if (c == v.waits) begin
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
      end else begin
        bus_rdata = ~v.rdata;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    e = sb.pop_front();
    check("done_stall", {31'b0, mem_stall}, 32'd0);
    check("done_req", {31'b0, bus_req}, 32'd0);
    check("mem_din", mem_din, e.din);
    check("req_count", rises, exp_rises);
  endtask

  task automatic go_idle();
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    #1 check("idle_nostall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    check("idle_noreq", {31'b0, bus_req}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    // ren, wen, b2b, addr, dout, rdata, waits, exp_we, exp_addr, exp_din
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, 32'h0000_0010, 32'h1234_5678};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'hFFFF_0000, 4, 1'b1, 32'h0000_0040, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h1000_0007, 32'h5555_5555, 32'hA5A5_5A5A, 2, 1'b0, 32'h1000_0004, 32'hA5A5_5A5A};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0022, 32'h1111_2222, 32'h7777_7777, 1, 1'b1, 32'h0000_0020, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0BAD_CAFE, 0, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_CAFE};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h9999_9999, 3, 1'b1, 32'h0000_0008, 32'h0BAD_CAFE};

    rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_din", mem_din, 32'd0);
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_we", {31'b0, bus_we}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_stall", {31'b0, mem_stall}, 32'd0);
    check("rst_timeout", {31'b0, bus_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stray ack with no request must be ignored
    bus_ack = 1'b1; bus_rdata = 32'hFEED_FACE;
    @(negedge clk);
    bus_ack = 1'b0;
    check("stray_ack_req", {31'b0, bus_req}, 32'd0);
    check("stray_ack_din", mem_din, 32'd0);
    go_idle();

    for (int i = 0; i < 6; i++) begin
      access(vecs[i]);
      @(negedge clk);
      check("no_reissue", {31'b0, bus_req}, 32'd0);
      if (!(i + 1 < 6 && vecs[i+1].b2b)) go_idle();
    end

    // Asynchronous reset in the middle of a pending read, request still held
    mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_0100;
    @(negedge clk);
    check("mid_req_up", {31'b0, bus_req}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, bus_req}, 32'd0);
    check("arst_stall", {31'b0, mem_stall}, 32'd0);
    check("arst_din", mem_din, 32'd0);
    check("arst_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_rises = rises;
    go_idle();
    access(vecs[0]);
    @(negedge clk);
    go_idle();

`ifdef DMEM_TIMEOUT_EN
    begin
      vec_t v;
      // Ack on the 8th REQ cycle beats the timeout
      v = '{1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h3141_5926, 7, 1'b0, 32'h0000_0080, 32'h3141_5926};
      access(v);
      check("late_ack_timeout", {31'b0, bus_timeout}, 32'd0);
      @(negedge clk);
      go_idle();

      mem_ren = 1'b1; mem_addr = 32'h0000_0084;
      exp_rises++;
      @(negedge clk);
      n = 0;
      while (bus_req && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("to_cycles", n, 32'd8);
      check("to_din", mem_din, 32'hDEAD_BEEF);
      check("to_flag", {31'b0, bus_timeout}, 32'd1);
      check("to_stall", {31'b0, mem_stall}, 32'd0);
      @(negedge clk);
      go_idle();
      access(vecs[2]);
      check("to_sticky", {31'b0, bus_timeout}, 32'd1);
      @(negedge clk);
      go_idle();
    end
`else
    check("timeout_tied", {31'b0, bus_timeout}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
